// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: holds the IF-stage prediction, resolves beq/bne,
// redirects fetch on a mispredict and returns a training update plus statistics.
module branch_resolve_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              if_branch,
    input  logic              if_pred_taken,
    input  logic [ADDR_W-1:0] if_pc_plus4,
    input  logic [ADDR_W-1:0] if_pc_target,
    input  logic              id_is_bne,
    input  logic [31:0]       id_rs1,
    input  logic [31:0]       id_rs2,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic              slot_pred_q, slot_pred_d;
    logic [ADDR_W-1:0] slot_plus4_q, slot_plus4_d;
    logic [ADDR_W-1:0] slot_target_q, slot_target_d;
    logic              resolve_c;
    logic              actual_c;
    logic              mis_c;

    // Slot control, resolve decision and same-cycle redirect
    always_comb begin
        state_d        = state_q;
        slot_pred_d    = slot_pred_q;
        slot_plus4_d   = slot_plus4_q;
        slot_target_d  = slot_target_q;
        resolve_c      = 1'b0;
        actual_c       = (id_rs1 == id_rs2) ^ id_is_bne;
        mis_c          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush_if       = 1'b0;
        case (state_q)
            EMPTY: begin
                if (if_branch && !stall) begin
                    state_d       = PENDING;
                    slot_pred_d   = if_pred_taken;
                    slot_plus4_d  = if_pc_plus4;
                    slot_target_d = if_pc_target;
                end
            end
            PENDING: begin
                if (!stall) begin
                    resolve_c = 1'b1;
                    mis_c     = actual_c != slot_pred_q;
                    if (mis_c) begin
                        // The squashed IF branch is dropped, never captured
                        redirect_valid = 1'b1;
                        flush_if       = 1'b1;
                        redirect_pc    = actual_c ? slot_target_q : slot_plus4_q;
                        state_d        = EMPTY;
                    end else if (if_branch) begin
                        slot_pred_d   = if_pred_taken;
                        slot_plus4_d  = if_pc_plus4;
                        slot_target_d = if_pc_target;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            slot_pred_q   <= 1'b0;
            slot_plus4_q  <= '0;
            slot_target_q <= '0;
        end else begin
            state_q       <= state_d;
            slot_pred_q   <= slot_pred_d;
            slot_plus4_q  <= slot_plus4_d;
            slot_target_q <= slot_target_d;
        end
    end

    // Training update and saturating statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            upd_valid <= resolve_c;
            if (resolve_c) begin
                upd_taken <= actual_c;
                if (br_count != CNT_MAX) begin
                    br_count <= br_count + CNT_W'(1);
                end
                if (mis_c && (mispred_count != CNT_MAX)) begin
                    mispred_count <= mispred_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
